// File: rtl/pipe_result_fifo_if.sv
// pipe_result_fifo_if: pipeline-side push and consumer-side valid/ready bundle for pipe_result_fifo.
// The overflow signal exists only when RESULT_FIFO_OVF_EN is defined.
interface pipe_result_fifo_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
);
   logic                       in_valid;
   logic [WIDTH-1:0]           in_data;
   logic                       in_ready;
   logic                       out_valid;
   logic [WIDTH-1:0]           out_data;
   logic                       out_ready;
   logic [$clog2(DEPTH):0]     count;
`ifdef RESULT_FIFO_OVF_EN
   logic                       overflow;
   modport master (output in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_data, count, overflow);
   modport slave  (input  in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_data, count, overflow);
`else
   modport master (output in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_data, count);
   modport slave  (input  in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_data, count);
`endif
endinterface

// File: rtl/pipe_result_fifo.sv
// pipe_result_fifo: register FIFO buffering a non-stallable result stream for a valid/ready consumer.
// Define RESULT_FIFO_OVF_EN to add the sticky overflow (drop) flag.
module pipe_result_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input logic              clk,
   input logic              n_rst,
   pipe_result_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    w_count_nxt;
   logic             w_full;
   logic             w_out_valid;
   logic             w_pop;
   logic             w_push;

   assign w_full      = (r_count == CW'(DEPTH));
   assign w_out_valid = (r_count != '0);
   assign w_pop       = w_out_valid && bus.out_ready;
   // A full FIFO still accepts a word when the head leaves on the same edge.
   assign w_push      = bus.in_valid && (!w_full || w_pop);

   assign bus.in_ready  = !w_full || bus.out_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = r_mem[r_rd_ptr];
   assign bus.count     = r_count;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop)
         w_count_nxt = r_count + CW'(1);
      else if (w_pop && !w_push)
         w_count_nxt = r_count - CW'(1);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
      end
   end

   // Storage is deliberately not reset; the pointers alone define contents.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= bus.in_data;
   end

`ifdef RESULT_FIFO_OVF_EN
   logic r_overflow;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         r_overflow <= 1'b0;
      else if (bus.in_valid && w_full && !w_pop)
         r_overflow <= 1'b1;
   end

   assign bus.overflow = r_overflow;
`endif

   a_count_range: assert property (@(posedge clk) disable iff (!n_rst) r_count <= CW'(DEPTH));
   a_ptr_gap: assert property (@(posedge clk) disable iff (!n_rst)
      (r_count == CW'(DEPTH)) || (r_count[AW-1:0] == AW'(r_wr_ptr - r_rd_ptr)));
endmodule
